// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI byte master between N_REQ chip-select-framed clients.
// Begin pulses from waiting clients are latched and replayed once that client owns the bus.
module spi_bus_arbiter #(
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_cs,
    input  logic [N_REQ-1:0]   req_tx_begin,
    input  logic [8*N_REQ-1:0] req_tx_data,
    output logic [N_REQ-1:0]   req_tx_end,
    output logic [7:0]         req_rx_data,
    output logic [N_REQ-1:0]   req_grant,
    output logic               m_tx_begin,
    output logic [7:0]         m_tx_data,
    input  logic               m_tx_end,
    input  logic [7:0]         m_rx_data,
    output logic [N_REQ-1:0]   spi_cs_n,
    output logic               protocol_err
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_XFER,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] cs_n_q, cs_n_d;
    logic [N_REQ-1:0] tx_end_q, tx_end_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             m_begin_q, m_begin_d;
    logic [7:0]       m_data_q, m_data_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] pend_vec;
    logic [N_REQ-1:0] begin_ok;
    logic [N_REQ-1:0] begin_bad;
    logic [7:0]       pdata_vec [N_REQ];
    logic [7:0]       cdata_vec [N_REQ];

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [N_REQ-1:0] arb_onehot;
    logic [N_REQ-1:0] owner_onehot;
    logic             owner_start;
    logic [7:0]       owner_byte;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return (v >= N_REQ) ? IDX_W'(v - N_REQ) : IDX_W'(v);
    endfunction

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_client
        logic       pend_q, pend_d;
        logic [7:0] pdata_q, pdata_d;
        logic       is_owner;
        logic       in_xfer;
        logic       served;

        assign is_owner       = (owner_q == IDX_W'(gi));
        assign in_xfer        = (state_q == S_XFER) && is_owner;
        assign served         = (state_q == S_ACTIVE) && is_owner;
        assign cdata_vec[gi]  = req_tx_data[8*gi +: 8];
        assign begin_bad[gi]  = req_tx_begin[gi] && (pend_q || in_xfer);
        assign begin_ok[gi]   = req_tx_begin[gi] && !pend_q && !in_xfer;
        assign pend_vec[gi]   = pend_q;
        assign pdata_vec[gi]  = pdata_q;

        // While the owner sits in ACTIVE its byte is either replayed or forwarded directly.
        always_comb begin
            pend_d  = pend_q;
            pdata_d = pdata_q;
            if (served) begin
                pend_d = 1'b0;
            end else if (begin_ok[gi]) begin
                pend_d  = 1'b1;
                pdata_d = cdata_vec[gi];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q  <= 1'b0;
                pdata_q <= 8'h00;
            end else begin
                pend_q  <= pend_d;
                pdata_q <= pdata_d;
            end
        end
    end

    // First low request scanning rr_q, rr_q+1, ...; lowest offset wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = rr_q;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (!req_cs[wrap_idx(int'(rr_q) + k)]) begin
                arb_found = 1'b1;
                arb_idx   = wrap_idx(int'(rr_q) + k);
            end
        end
    end

    assign arb_onehot   = N_REQ'(1) << arb_idx;
    assign owner_onehot = N_REQ'(1) << owner_q;
    assign owner_start  = pend_vec[owner_q] || begin_ok[owner_q];
    assign owner_byte   = pend_vec[owner_q] ? pdata_vec[owner_q] : cdata_vec[owner_q];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        gap_cnt_d = gap_cnt_q;
        grant_d   = grant_q;
        cs_n_d    = cs_n_q;
        tx_end_d  = '0;
        rx_data_d = rx_data_q;
        m_begin_d = 1'b0;
        m_data_d  = m_data_q;
        err_d     = err_q | (|begin_bad);

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d = S_ACTIVE;
                    owner_d = arb_idx;
                    grant_d = arb_onehot;
                    cs_n_d  = ~arb_onehot;
                end
            end
            S_ACTIVE: begin
                if (owner_start) begin
                    state_d   = S_XFER;
                    m_begin_d = 1'b1;
                    m_data_d  = owner_byte;
                end else if (req_cs[owner_q]) begin
                    state_d   = S_RELEASE;
                    grant_d   = '0;
                    cs_n_d    = '1;
                    gap_cnt_d = '0;
                    rr_d      = wrap_idx(int'(owner_q) + 1);
                end
            end
            S_XFER: begin
                if (m_tx_end) begin
                    state_d   = S_ACTIVE;
                    rx_data_d = m_rx_data;
                    tx_end_d  = owner_onehot;
                end
            end
            S_RELEASE: begin
                // Arbitrating in the last gap cycle keeps all-CS-high to exactly GAP_CYCLES.
                if (gap_cnt_q == GAP_LAST) begin
                    if (arb_found) begin
                        state_d = S_ACTIVE;
                        owner_d = arb_idx;
                        grant_d = arb_onehot;
                        cs_n_d  = ~arb_onehot;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            rr_q      <= '0;
            gap_cnt_q <= '0;
            grant_q   <= '0;
            cs_n_q    <= '1;
            tx_end_q  <= '0;
            rx_data_q <= 8'h00;
            m_begin_q <= 1'b0;
            m_data_q  <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            gap_cnt_q <= gap_cnt_d;
            grant_q   <= grant_d;
            cs_n_q    <= cs_n_d;
            tx_end_q  <= tx_end_d;
            rx_data_q <= rx_data_d;
            m_begin_q <= m_begin_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
        end
    end

    assign req_tx_end   = tx_end_q;
    assign req_rx_data  = rx_data_q;
    assign req_grant    = grant_q;
    assign m_tx_begin   = m_begin_q;
    assign m_tx_data    = m_data_q;
    assign spi_cs_n     = cs_n_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scenario tasks plus a randomized run scored against a transaction-level client/master model.
module tb_spi_bus_arbiter;
    localparam int N_REQ      = 2;
    localparam int GAP_CYCLES = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_REQ-1:0]   req_cs;
    logic [N_REQ-1:0]   req_tx_begin;
    logic [8*N_REQ-1:0] req_tx_data;
    logic [N_REQ-1:0]   req_tx_end;
    logic [7:0]         req_rx_data;
    logic [N_REQ-1:0]   req_grant;
    logic               m_tx_begin;
    logic [7:0]         m_tx_data;
    logic               m_tx_end;
    logic [7:0]         m_rx_data;
    logic [N_REQ-1:0]   spi_cs_n;
    logic               protocol_err;

    int n_vec = 0;
    int n_err = 0;

    spi_bus_arbiter #(.N_REQ(N_REQ), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req_cs(req_cs), .req_tx_begin(req_tx_begin), .req_tx_data(req_tx_data),
        .req_tx_end(req_tx_end), .req_rx_data(req_rx_data), .req_grant(req_grant),
        .m_tx_begin(m_tx_begin), .m_tx_data(m_tx_data),
        .m_tx_end(m_tx_end), .m_rx_data(m_rx_data),
        .spi_cs_n(spi_cs_n), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_cs       = '1;
        req_tx_begin = '0;
        req_tx_data  = '0;
        m_tx_end     = 1'b0;
        m_rx_data    = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_m_begin(input int limit);
        for (int k = 0; k < limit && m_tx_begin !== 1'b1; k++) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (spi_cs_n !== 2'b11) begin n_err++; $display("FAIL rst_cs: got %b want 11", spi_cs_n); end
        n_vec++; if (req_grant !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b want 00", req_grant); end
        n_vec++; if (req_tx_end !== 2'b00) begin n_err++; $display("FAIL rst_tx_end: got %b want 00", req_tx_end); end
        n_vec++; if (req_rx_data !== 8'h00) begin n_err++; $display("FAIL rst_rx: got %h want 00", req_rx_data); end
        n_vec++; if (m_tx_begin !== 1'b0) begin n_err++; $display("FAIL rst_mbegin: got %b want 0", m_tx_begin); end
        n_vec++; if (m_tx_data !== 8'h00) begin n_err++; $display("FAIL rst_mdata: got %h want 00", m_tx_data); end
        n_vec++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", protocol_err); end
        for (int k = 0; k < 4; k++) tick();
        n_vec++; if (spi_cs_n !== 2'b11) begin n_err++; $display("FAIL idle_cs: got %b want 11", spi_cs_n); end
        $display("test_reset done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_single();
        do_reset();
        req_cs = 2'b10; req_tx_begin = 2'b01; req_tx_data = {8'($urandom), 8'hE8};
        tick();
        req_tx_begin = '0;
        n_vec++; if (spi_cs_n !== 2'b10) begin n_err++; $display("FAIL t1_cs: got %b want 10", spi_cs_n); end
        n_vec++; if (req_grant !== 2'b01) begin n_err++; $display("FAIL t1_grant: got %b want 01", req_grant); end
        n_vec++; if (m_tx_begin !== 1'b0) begin n_err++; $display("FAIL t1_early_begin: got %b want 0", m_tx_begin); end
        tick();
        n_vec++; if (m_tx_begin !== 1'b1 || m_tx_data !== 8'hE8) begin
            n_err++; $display("FAIL t1_mbegin: got %b/%h want 1/e8", m_tx_begin, m_tx_data); end
        tick();
        n_vec++; if (m_tx_begin !== 1'b0 || m_tx_data !== 8'hE8) begin
            n_err++; $display("FAIL t1_pulse: got %b/%h want 0/e8", m_tx_begin, m_tx_data); end
        m_tx_end = 1'b1; m_rx_data = 8'h5A;
        tick();
        m_tx_end = 1'b0;
        n_vec++; if (req_tx_end !== 2'b01 || req_rx_data !== 8'h5A) begin
            n_err++; $display("FAIL t1_end: got %b/%h want 01/5a", req_tx_end, req_rx_data); end
        tick();
        n_vec++; if (req_tx_end !== 2'b00) begin n_err++; $display("FAIL t1_end_pulse: got %b want 00", req_tx_end); end
        req_cs = 2'b11;
        tick();
        n_vec++; if (spi_cs_n !== 2'b11 || req_grant !== 2'b00) begin
            n_err++; $display("FAIL t1_release: got %b/%b want 11/00", spi_cs_n, req_grant); end
        $display("test_single done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_contention();
        int gap;
        do_reset();
        req_cs = 2'b00;
        tick();
        n_vec++; if (req_grant !== 2'b01 || spi_cs_n !== 2'b10) begin
            n_err++; $display("FAIL t2_first: got %b/%b want 01/10", req_grant, spi_cs_n); end
        req_cs = 2'b01;
        tick();
        gap = 0;
        while (spi_cs_n === 2'b11 && gap < 200) begin gap++; tick(); end
        n_vec++; if (gap != GAP_CYCLES) begin n_err++; $display("FAIL t2_gap1: got %0d want %0d", gap, GAP_CYCLES); end
        n_vec++; if (req_grant !== 2'b10 || spi_cs_n !== 2'b01) begin
            n_err++; $display("FAIL t2_second: got %b/%b want 10/01", req_grant, spi_cs_n); end
        req_cs = 2'b10;
        tick();
        req_cs = 2'b00;
        gap = 0;
        while (spi_cs_n === 2'b11 && gap < 200) begin gap++; tick(); end
        n_vec++; if (gap != GAP_CYCLES) begin n_err++; $display("FAIL t2_gap2: got %0d want %0d", gap, GAP_CYCLES); end
        n_vec++; if (req_grant !== 2'b01 || spi_cs_n !== 2'b10) begin
            n_err++; $display("FAIL t2_rr: got %b/%b want 01/10", req_grant, spi_cs_n); end
        $display("test_contention done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_latched();
        int pulses;
        do_reset();
        req_cs = 2'b10; req_tx_begin = 2'b01; req_tx_data = 16'h0011;
        tick();
        req_tx_begin = '0;
        wait_m_begin(10);
        n_vec++; if (m_tx_begin !== 1'b1 || m_tx_data !== 8'h11) begin
            n_err++; $display("FAIL t3_first: got %b/%h want 1/11", m_tx_begin, m_tx_data); end
        req_cs = 2'b00; req_tx_begin = 2'b10; req_tx_data = 16'h2000;
        tick();
        req_tx_begin = '0;
        tick();
        m_tx_end = 1'b1; m_rx_data = 8'h77;
        tick();
        m_tx_end = 1'b0;
        n_vec++; if (req_tx_end !== 2'b01 || req_rx_data !== 8'h77) begin
            n_err++; $display("FAIL t3_end0: got %b/%h want 01/77", req_tx_end, req_rx_data); end
        pulses = 0;
        for (int k = 0; k < 6; k++) begin tick(); if (m_tx_begin === 1'b1) pulses++; end
        n_vec++; if (pulses != 0 || req_grant !== 2'b01) begin
            n_err++; $display("FAIL t3_hold: got %0d pulses grant %b want 0 pulses grant 01", pulses, req_grant); end
        req_cs = 2'b01;
        wait_m_begin(100);
        n_vec++; if (m_tx_begin !== 1'b1 || m_tx_data !== 8'h20 || spi_cs_n !== 2'b01) begin
            n_err++; $display("FAIL t3_fwd: got %b/%h cs %b want 1/20 cs 01", m_tx_begin, m_tx_data, spi_cs_n); end
        m_tx_end = 1'b1; m_rx_data = 8'h9C;
        tick();
        m_tx_end = 1'b0;
        n_vec++; if (req_tx_end !== 2'b10 || req_rx_data !== 8'h9C) begin
            n_err++; $display("FAIL t3_end1: got %b/%h want 10/9c", req_tx_end, req_rx_data); end
        pulses = 0;
        for (int k = 0; k < 10; k++) begin tick(); if (m_tx_begin === 1'b1) pulses++; end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL t3_once: got %0d extra pulses want 0", pulses); end
        n_vec++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL t3_err: got %b want 0", protocol_err); end
        $display("test_latched done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_deferred();
        int lows;
        do_reset();
        req_cs = 2'b10; req_tx_begin = 2'b01; req_tx_data = 16'h0033;
        tick();
        req_tx_begin = '0;
        wait_m_begin(10);
        n_vec++; if (m_tx_begin !== 1'b1) begin n_err++; $display("FAIL t4_begin_timeout: got %b want 1", m_tx_begin); end
        req_cs = 2'b11;
        lows = 0;
        for (int k = 0; k < 4; k++) begin tick(); if (spi_cs_n[0] === 1'b0) lows++; end
        n_vec++; if (lows != 4) begin n_err++; $display("FAIL t4_cs_held: got %0d low cycles want 4", lows); end
        m_tx_end = 1'b1; m_rx_data = 8'hC3;
        tick();
        m_tx_end = 1'b0;
        n_vec++; if (req_tx_end !== 2'b01 || req_rx_data !== 8'hC3 || spi_cs_n !== 2'b10) begin
            n_err++; $display("FAIL t4_end: got %b/%h cs %b want 01/c3 cs 10", req_tx_end, req_rx_data, spi_cs_n); end
        tick();
        n_vec++; if (spi_cs_n !== 2'b11 || req_grant !== 2'b00) begin
            n_err++; $display("FAIL t4_release: got %b/%b want 11/00", spi_cs_n, req_grant); end
        $display("test_deferred done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_error();
        do_reset();
        req_cs = 2'b10;
        tick();
        req_tx_begin = 2'b10; req_tx_data = 16'h4400;
        tick();
        req_tx_data = 16'h5500;
        n_vec++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL t5_no_err: got %b want 0", protocol_err); end
        tick();
        req_tx_begin = '0;
        n_vec++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL t5_err: got %b want 1", protocol_err); end
        req_cs = 2'b01;
        wait_m_begin(100);
        n_vec++; if (m_tx_begin !== 1'b1 || m_tx_data !== 8'h44) begin
            n_err++; $display("FAIL t5_kept: got %b/%h want 1/44", m_tx_begin, m_tx_data); end
        n_vec++; if (protocol_err !== 1'b1) begin n_err++; $display("FAIL t5_sticky: got %b want 1", protocol_err); end
        $display("test_error done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        req_cs = 2'b10; req_tx_begin = 2'b11; req_tx_data = 16'h9966;
        tick();
        req_tx_begin = 2'b10; req_tx_data = 16'h9A00;
        tick();
        req_tx_begin = '0;
        wait_m_begin(10);
        tick();
        req_cs = 2'b11; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (spi_cs_n !== 2'b11 || req_grant !== 2'b00 || req_tx_end !== 2'b00) begin
            n_err++; $display("FAIL t6_cs_grant: got %b/%b/%b want 11/00/00", spi_cs_n, req_grant, req_tx_end); end
        n_vec++; if (m_tx_begin !== 1'b0 || m_tx_data !== 8'h00 || req_rx_data !== 8'h00) begin
            n_err++; $display("FAIL t6_data: got %b/%h/%h want 0/00/00", m_tx_begin, m_tx_data, req_rx_data); end
        n_vec++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL t6_err: got %b want 0", protocol_err); end
        req_cs = 2'b01;
        tick();
        n_vec++; if (req_grant !== 2'b10) begin n_err++; $display("FAIL t6_grant1: got %b want 10", req_grant); end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin tick(); if (m_tx_begin === 1'b1) pulses++; end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL t6_pend_cleared: got %0d pulses want 0", pulses); end
        $display("test_reset_mid done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_random();
        int         remaining [N_REQ];
        bit         active [N_REQ];
        bit         busy [N_REQ];
        bit         exp_valid [N_REQ];
        logic [7:0] exp_byte [N_REQ];
        logic [7:0] exp_rx;
        logic [7:0] d;
        logic [N_REQ-1:0] cs_low, prev_low, exp_end;
        bit  xfer_active, end_prev, stopping, all_quiet;
        int  timer, xfer_owner, end_owner, owner, high_run, n_bytes;
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            remaining[i] = 0; active[i] = 0; busy[i] = 0; exp_valid[i] = 0; exp_byte[i] = 8'h00;
        end
        exp_rx = 8'h00; xfer_active = 0; end_prev = 0; timer = 0;
        xfer_owner = 0; end_owner = 0; prev_low = '0; high_run = GAP_CYCLES; n_bytes = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            stopping = (cyc >= 2500);
            tick();
            cs_low  = ~spi_cs_n;
            exp_end = end_prev ? (N_REQ'(1) << end_owner) : '0;
            n_vec++; if (req_tx_end !== exp_end) begin
                n_err++; $display("FAIL rnd_tx_end c%0d: got %b want %b", cyc, req_tx_end, exp_end); end
            if (end_prev) begin
                n_vec++; if (req_rx_data !== exp_rx) begin
                    n_err++; $display("FAIL rnd_rx c%0d: got %h want %h", cyc, req_rx_data, exp_rx); end
            end
            n_vec++; if ($countones(cs_low) > 1 || req_grant !== cs_low) begin
                n_err++; $display("FAIL rnd_owner c%0d: cs_n %b grant %b", cyc, spi_cs_n, req_grant); end
            if (cs_low == '0) begin
                high_run++;
            end else begin
                if (cs_low != prev_low) begin
                    n_vec++; if (prev_low != '0 || high_run < GAP_CYCLES) begin
                        n_err++; $display("FAIL rnd_gap c%0d: got %0d high cycles want >= %0d", cyc, high_run, GAP_CYCLES); end
                end
                high_run = 0;
            end
            prev_low = cs_low;
            m_tx_end = 1'b0;
            if (m_tx_begin === 1'b1) begin
                owner = 0;
                for (int k = 0; k < N_REQ; k++) if (cs_low[k]) owner = k;
                n_vec++;
                if (cs_low == '0 || !exp_valid[owner] || m_tx_data !== exp_byte[owner]) begin
                    n_err++; $display("FAIL rnd_byte c%0d: got %h cs_n %b want %h", cyc, m_tx_data, spi_cs_n, exp_byte[owner]);
                end
                exp_valid[owner] = 0;
                xfer_active = 1; xfer_owner = owner; timer = $urandom_range(0, 3);
            end
            if (xfer_active) begin
                if (timer == 0) begin
                    m_tx_end = 1'b1; m_rx_data = 8'($urandom); exp_rx = m_rx_data;
                    end_owner = xfer_owner; xfer_active = 0; n_bytes++;
                end else begin
                    timer--;
                end
            end
            end_prev = m_tx_end;
            req_tx_begin = '0;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_tx_end[i] === 1'b1) busy[i] = 0;
                if (!active[i]) begin
                    if (!stopping && $urandom_range(0, 7) == 0) begin
                        active[i] = 1; remaining[i] = $urandom_range(0, 3);
                    end
                end else if (!busy[i] && remaining[i] > 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        d = 8'($urandom);
                        exp_byte[i] = d; exp_valid[i] = 1; busy[i] = 1; remaining[i]--;
                        req_tx_begin[i] = 1'b1; req_tx_data[8*i +: 8] = d;
                    end
                end else if (!busy[i]) begin
                    active[i] = 0;
                end
                req_cs[i] = ~active[i];
            end
            all_quiet = !xfer_active && !end_prev && (spi_cs_n === '1);
            for (int i = 0; i < N_REQ; i++) if (active[i]) all_quiet = 0;
            if (stopping && all_quiet) break;
        end
        all_quiet = 1;
        for (int i = 0; i < N_REQ; i++) if (active[i] || exp_valid[i]) all_quiet = 0;
        n_vec++; if (!all_quiet) begin n_err++; $display("FAIL rnd_drain: clients still outstanding after cycle budget"); end
        n_vec++; if (n_bytes < 10) begin n_err++; $display("FAIL rnd_traffic: got %0d bytes want >= 10", n_bytes); end
        n_vec++; if (protocol_err !== 1'b0) begin n_err++; $display("FAIL rnd_err: got %b want 0", protocol_err); end
        $display("test_random done: bytes=%0d vectors=%0d miscompares=%0d", n_bytes, n_vec, n_err);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_latched();
        test_deferred();
        test_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
